dac_serializer: RTL and testbench
=================================

# dac_serializer

Parallel-to-serial transmitter that takes one N-bit fixed-point sample from the datapath's enabled sample registers and shifts it out MSB-first on a 3-wire SPI-style DAC link (sclk, sdo, cs_n). It sits at the output end of the sample path, after the pipeline registers, and is the outbound counterpart of the input capture stage. Each accepted word produces exactly one chip-select frame.

## Interface
Parameters:
- N, default `N` (18): sample width in bits; comes from the shared constants header.
- CLK_DIV, default 4: clk cycles per sclk half-period; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- datos  input  N  sample to transmit; sampled only on the accepting edge.
- start  input  1  request; a word is accepted on a rising clk edge where start=1 and ready=1.
- ready  output  1  high when idle and able to accept; reset value 1.
- done  output  1  one-cycle pulse when a frame completes; reset value 0.
- cs_n  output  1  DAC chip select, active-low; reset value 1.
- sclk  output  1  serial clock, idle low; reset value 0.
- sdo  output  1  serial data, MSB first; reset value 0.

## Operation
- FSM states: IDLE, SHIFT, END.
- IDLE: ready=1, cs_n=1, sclk=0, sdo=0.
  - On start=1, capture datos into a shift register and load the bit counter with N.
  - Go to SHIFT.
- SHIFT:
  - ready=0, cs_n=0, sdo = shift register MSB.
  - A divide counter counts 0..CLK_DIV-1. sclk toggles when it wraps.
  - On each sclk falling toggle, shift left by one and decrement the bit counter.
  - When the counter reaches 0 on that falling toggle, go to END.
- END, one cycle: cs_n=1, sclk=0, sdo=0, done=1, ready=0. Then return to IDLE.
- Data changes only on sclk falling edges, so the DAC samples on sclk rising edges.
- start while ready=0 is ignored and not queued. datos is don't-care outside the accepting edge.
- All outputs are registered. There is no combinational path from start or datos to any output.
- Reset asserted at any time, including mid-frame: immediate return to IDLE with the reset values above. The frame is aborted, and no done pulse is produced.

## Timing
- Let T0 be the accepting edge.
- After T0: cs_n=0 and sdo=datos[N-1].
- sclk rising edge k (k=1..N) occurs at T0+(2k-1)·CLK_DIV. Falling edge k occurs at T0+2k·CLK_DIV.
- sdo holds datos[N-k] from falling edge k-1 (T0 for k=1) until falling edge k.
- After edge T0+2N·CLK_DIV: END. cs_n=1, done=1 for exactly one cycle.
- After edge T0+2N·CLK_DIV+1: ready=1.
- Minimum frame period with start held high: 2N·CLK_DIV+2 cycles. Next accept at T0+2N·CLK_DIV+2; cs_n is high for at least 2 cycles between frames.
- N=18, CLK_DIV=4: 144 cycles of cs_n low, 146-cycle period.

## Structure
- Shared constants header: `N`, and the FSM state encoding (IDLE/SHIFT/END as localparams).
- Counter widths:
  - bit counter: $clog2(N+1) bits.
  - divide counter: $clog2(CLK_DIV) bits, minimum 1.
- One sub-module is natural: sclk_tick_gen. It is the divide counter, emits rise/fall strobes and the sclk level, and is enabled only in SHIFT.
- Remaining logic (FSM, shift register, bit counter) is in dac_serializer.

## Test plan
- datos=18'h2A5A5, CLK_DIV=4, single start pulse:
  - sdo sampled on sclk rising edges = 10_1010_0101_1010_0101.
  - exactly 18 sclk rises; cs_n low for 144 cycles.
  - done high for exactly 1 cycle; ready high 1 cycle later.
- start held high, datos=18'h3FFFF then 18'h00000:
  - two frames, accepts 146 cycles apart.
  - first frame sdo all 1, second all 0.
  - cs_n high for exactly 2 cycles between frames.
- start pulsed during SHIFT with datos=18'h12345 while frame 18'h2A5A5 is in flight:
  - the in-flight frame is unchanged.
  - no second frame occurs without a new start after ready=1.
- reset driven low at cycle 50 of a frame:
  - same cycle: cs_n=1, sclk=0, sdo=0, ready=1, done=0.
  - no done pulse.
  - a new frame after release transmits correctly.
- CLK_DIV=1, datos=18'h20001:
  - sclk toggles every cycle; 36-cycle cs_n-low window.
  - sdo = 1, sixteen 0s, then 1.

Source files
------------

// File: rtl/dac_serializer_pkg.sv
// Shared constants for the DAC output serializer: default sample width and FSM encoding.
package dac_serializer_pkg;

  localparam int DAC_N = 18;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_END   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    END   = ST_END
  } state_t;

  // Counter width that stays at least one bit wide for degenerate ranges.
  function automatic int width_min1(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/dac_serializer_sclk_tick_gen.sv
// Divide counter producing the serial clock level and a falling-toggle strobe.
module sclk_tick_gen
  import dac_serializer_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic fall
);

  localparam int DIV_W = width_min1(CLK_DIV);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             sclk_reg;
  logic             wrap;

  assign wrap = en && (div_cnt_reg == DIV_W'(CLK_DIV - 1));

  // Held cleared while disabled so every frame starts a fresh half-period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
    end else if (wrap) begin
      div_cnt_reg <= '0;
      sclk_reg    <= ~sclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign sclk = sclk_reg;
  assign fall = wrap & sclk_reg;

endmodule

// File: rtl/dac_serializer.sv
// MSB-first serializer of one N-bit sample per chip-select frame on a 3-wire DAC link.
module dac_serializer
  import dac_serializer_pkg::*;
#(
  parameter int N       = DAC_N,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] datos,
  input  logic         start,
  output logic         ready,
  output logic         done,
  output logic         cs_n,
  output logic         sclk,
  output logic         sdo
);

  localparam int BW = $clog2(N + 1);

  state_t         state_reg, state_next;
  logic [N-1:0]   shreg_reg, shreg_next;
  logic [BW-1:0]  bitcnt_reg, bitcnt_next;
  logic           ready_reg, ready_next;
  logic           done_reg, done_next;
  logic           cs_n_reg, cs_n_next;
  logic           sdo_reg, sdo_next;
  logic           sclk_fall;
  logic [N-1:0]   shifted;

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state_reg == SHIFT),
    .sclk  (sclk),
    .fall  (sclk_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
      ready_reg  <= 1'b1;
      done_reg   <= 1'b0;
      cs_n_reg   <= 1'b1;
      sdo_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shreg_reg  <= shreg_next;
      bitcnt_reg <= bitcnt_next;
      ready_reg  <= ready_next;
      done_reg   <= done_next;
      cs_n_reg   <= cs_n_next;
      sdo_reg    <= sdo_next;
    end
  end

  assign shifted = {shreg_reg[N-2:0], 1'b0};

  // Outputs are computed one cycle ahead so every pin comes straight off a flop.
  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    bitcnt_next = bitcnt_reg;
    ready_next  = ready_reg;
    done_next   = 1'b0;
    cs_n_next   = cs_n_reg;
    sdo_next    = sdo_reg;
    case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        cs_n_next  = 1'b1;
        sdo_next   = 1'b0;
        if (start) begin
          state_next  = SHIFT;
          shreg_next  = datos;
          bitcnt_next = BW'(N);
          ready_next  = 1'b0;
          cs_n_next   = 1'b0;
          sdo_next    = datos[N-1];
        end
      end
      SHIFT: begin
        if (sclk_fall) begin
          shreg_next  = shifted;
          bitcnt_next = bitcnt_reg - 1'b1;
          sdo_next    = shifted[N-1];
          if (bitcnt_reg == BW'(1)) begin
            state_next = END;
            cs_n_next  = 1'b1;
            sdo_next   = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      END: begin
        state_next = IDLE;
        ready_next = 1'b1;
      end
      default: begin
        state_next = IDLE;
        ready_next = 1'b1;
        cs_n_next  = 1'b1;
        sdo_next   = 1'b0;
      end
    endcase
  end

  assign ready = ready_reg;
  assign done  = done_reg;
  assign cs_n  = cs_n_reg;
  assign sdo   = sdo_reg;

endmodule

// File: tb/tb_dac_serializer.sv
// Scoreboard bench for dac_serializer with CLK_DIV=4 and CLK_DIV=1 instances.
module tb_dac_serializer;
  import dac_serializer_pkg::*;

  localparam int NB = DAC_N;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          start [2];
  logic [NB-1:0] datos [2];
  logic          ready [2];
  logic          done  [2];
  logic          cs_n  [2];
  logic          sclk  [2];
  logic          sdo   [2];

  dac_serializer #(.N(NB), .CLK_DIV(4)) u_div4 (
    .clk(clk), .reset(reset), .datos(datos[0]), .start(start[0]),
    .ready(ready[0]), .done(done[0]), .cs_n(cs_n[0]), .sclk(sclk[0]), .sdo(sdo[0])
  );

  dac_serializer #(.N(NB), .CLK_DIV(1)) u_div1 (
    .clk(clk), .reset(reset), .datos(datos[1]), .start(start[1]),
    .ready(ready[1]), .done(done[1]), .cs_n(cs_n[1]), .sclk(sclk[1]), .sdo(sdo[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic exp_q0[$];
  logic exp_q1[$];
  int   rises [2];
  int   lows  [2];
  int   dones [2];
  logic prev_sclk [2];

  // Monitor: every sclk rising edge pops one expected bit and compares sdo.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (sclk[s] === 1'b1 && prev_sclk[s] === 1'b0) begin
        rises[s]++;
        if (s == 0) begin
          if (exp_q0.size() > 0) check_eq("div4_sdo_bit", 32'(sdo[s]), 32'(exp_q0.pop_front()));
          else check_eq("div4_rise_without_bit", 32'(exp_q0.size()), 1);
        end else begin
          if (exp_q1.size() > 0) check_eq("div1_sdo_bit", 32'(sdo[s]), 32'(exp_q1.pop_front()));
          else check_eq("div1_rise_without_bit", 32'(exp_q1.size()), 1);
        end
      end
      if (cs_n[s] === 1'b0) lows[s]++;
      if (done[s] === 1'b1) dones[s]++;
      prev_sclk[s] = sclk[s];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_bits(input int s, input logic [NB-1:0] d);
    for (int i = NB - 1; i >= 0; i--) begin
      if (s == 0) exp_q0.push_back(d[i]);
      else        exp_q1.push_back(d[i]);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic wait_ready(input int s);
    int k = 0;
    while (ready[s] !== 1'b1 && k < 500) begin
      tick();
      k++;
    end
    if (ready[s] !== 1'b1) check_eq("ready_wait_timeout", 32'(ready[s]), 1);
  endtask

  task automatic run_frame(input int s, input logic [NB-1:0] d, input bit mid_start);
    int cdiv, flen, b_low, b_rise, b_done, k;
    cdiv = (s == 0) ? 4 : 1;
    flen = 2 * NB * cdiv;
    wait_ready(s);
    b_low = lows[s]; b_rise = rises[s]; b_done = dones[s];
    datos[s] = d;
    start[s] = 1'b1;
    push_bits(s, d);
    tick();
    start[s] = 1'b0;
    datos[s] = NB'($urandom);
    check_eq("frame_cs_low", 32'(cs_n[s]), 0);
    check_eq("frame_first_sdo", 32'(sdo[s]), 32'(d[NB-1]));
    check_eq("frame_ready_low", 32'(ready[s]), 0);
    k = 1;
    while (done[s] !== 1'b1 && k < flen + 20) begin
      if (mid_start && k == 50) begin
        start[s] = 1'b1;
        datos[s] = 18'h12345;
      end else begin
        start[s] = 1'b0;
      end
      tick();
      k++;
    end
    start[s] = 1'b0;
    check_eq("done_time", 32'(k), 32'(flen + 1));
    tick();
    check_eq("done_width", 32'(done[s]), 0);
    check_eq("ready_after_done", 32'(ready[s]), 1);
    check_eq("cs_low_cycles", 32'(lows[s] - b_low), 32'(flen));
    check_eq("sclk_rises", 32'(rises[s] - b_rise), 32'(NB));
    check_eq("done_pulses", 32'(dones[s] - b_done), 1);
    check_eq("bits_consumed", 32'(qsize(s)), 0);
    if (mid_start) begin
      repeat (30) tick();
      check_eq("no_queued_frame_lows", 32'(lows[s] - b_low), 32'(flen));
      check_eq("no_queued_frame_done", 32'(dones[s] - b_done), 1);
    end
    $display("frame dut%0d data=%05h cdiv=%0d done_at=%0d", s, d, cdiv, k);
  endtask

  initial begin
    int k, hi, b_rise, b_done;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0;
      datos[s] = '0;
      rises[s] = 0;
      lows[s]  = 0;
      dones[s] = 0;
      prev_sclk[s] = 1'b0;
    end
    reset = 1'b0;
    repeat (3) tick();
    check_eq("rst_ready", 32'(ready[0]), 1);
    check_eq("rst_done",  32'(done[0]),  0);
    check_eq("rst_cs_n",  32'(cs_n[0]),  1);
    check_eq("rst_sclk",  32'(sclk[0]),  0);
    check_eq("rst_sdo",   32'(sdo[0]),   0);
    reset = 1'b1;
    tick();

    run_frame(0, 18'h2A5A5, 1'b0);
    run_frame(0, 18'h2A5A5, 1'b1);

    // start held high: two back-to-back frames
    wait_ready(0);
    b_rise = rises[0]; b_done = dones[0];
    datos[0] = 18'h3FFFF;
    start[0] = 1'b1;
    push_bits(0, 18'h3FFFF);
    push_bits(0, 18'h00000);
    tick();
    datos[0] = 18'h00000;
    check_eq("held_first_cs", 32'(cs_n[0]), 0);
    k = 1; hi = 0;
    while (k < 400 && !(cs_n[0] === 1'b0 && hi > 0)) begin
      tick();
      k++;
      if (cs_n[0] === 1'b1) hi++;
    end
    start[0] = 1'b0;
    check_eq("held_second_accept", 32'(k), 32'(2 * NB * 4 + 3));
    check_eq("held_cs_gap", 32'(hi), 2);
    k = 0;
    while (!(ready[0] === 1'b1 && cs_n[0] === 1'b1) && k < 400) begin
      tick();
      k++;
    end
    check_eq("held_bits_consumed", 32'(exp_q0.size()), 0);
    check_eq("held_rises", 32'(rises[0] - b_rise), 32'(2 * NB));
    check_eq("held_dones", 32'(dones[0] - b_done), 2);
    $display("held frames second_accept_gap=%0d", hi);

    // reset in the middle of a frame
    wait_ready(0);
    b_done = dones[0];
    datos[0] = 18'h2A5A5;
    start[0] = 1'b1;
    push_bits(0, 18'h2A5A5);
    tick();
    start[0] = 1'b0;
    repeat (49) tick();
    reset = 1'b0;
    #1;
    check_eq("midrst_cs_n",  32'(cs_n[0]),  1);
    check_eq("midrst_sclk",  32'(sclk[0]),  0);
    check_eq("midrst_sdo",   32'(sdo[0]),   0);
    check_eq("midrst_ready", 32'(ready[0]), 1);
    check_eq("midrst_done",  32'(done[0]),  0);
    exp_q0.delete();
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    check_eq("midrst_no_done", 32'(dones[0] - b_done), 0);
    $display("mid-frame reset applied at cycle 50");
    run_frame(0, 18'h2A5A5, 1'b0);

    run_frame(1, 18'h20001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
